wb_stage_ext: RTL and testbench

- Parametrised write-back stage for the 5-stage MIPS pipeline. Contains the MEM/WB pipeline register and its enable/flush controls.
- Registers MEM-stage results, then:
  - extracts and extends sub-word load data;
  - selects the write-back source (ALU result, load data, or link address);
  - drives the register-file write port.
- Also provides a retired-instruction counter and a sticky halt flag for the debug unit.

---
 rtl/wb_stage_ext_if.sv | 50 +++++
 rtl/wb_stage_ext.sv | 113 +++++++++++
 tb/tb_wb_stage_ext.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_stage_ext_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage_ext_if
// Brief    : MEM-to-WB bundle: pipeline controls, MEM results, WB outputs.
// Revision : 1.0
// ============================================================================
interface wb_stage_ext_if #(
    parameter int NB_DATA = 32,
    parameter int NB_REG  = 5,
    parameter int NB_PC   = 32,
    parameter int NB_CNT  = 32
);
    logic               i_enable;
    logic               i_flush;
    logic               i_MEM_valid;
    logic               i_MEM_reg_write;
    logic               i_MEM_mem_to_reg;
    logic               i_MEM_r31_ctrl;
    logic [1:0]         i_MEM_load_size;
    logic               i_MEM_load_unsigned;
    logic [1:0]         i_MEM_byte_offset;
    logic [NB_DATA-1:0] i_MEM_mem_data;
    logic [NB_DATA-1:0] i_MEM_alu_result;
    logic [NB_REG-1:0]  i_MEM_selected_reg;
    logic [NB_PC-1:0]   i_MEM_pc;
    logic               i_MEM_halt;
    logic               o_WB_reg_write;
    logic [NB_REG-1:0]  o_WB_selected_reg;
    logic [NB_DATA-1:0] o_WB_selected_data;
    logic               o_WB_valid;
    logic               o_WB_halt;
    logic [NB_CNT-1:0]  o_retired_count;

    modport master (
        output i_enable, i_flush, i_MEM_valid, i_MEM_reg_write, i_MEM_mem_to_reg,
               i_MEM_r31_ctrl, i_MEM_load_size, i_MEM_load_unsigned, i_MEM_byte_offset,
               i_MEM_mem_data, i_MEM_alu_result, i_MEM_selected_reg, i_MEM_pc, i_MEM_halt,
        input  o_WB_reg_write, o_WB_selected_reg, o_WB_selected_data, o_WB_valid,
               o_WB_halt, o_retired_count
    );

    modport slave (
        input  i_enable, i_flush, i_MEM_valid, i_MEM_reg_write, i_MEM_mem_to_reg,
               i_MEM_r31_ctrl, i_MEM_load_size, i_MEM_load_unsigned, i_MEM_byte_offset,
               i_MEM_mem_data, i_MEM_alu_result, i_MEM_selected_reg, i_MEM_pc, i_MEM_halt,
        output o_WB_reg_write, o_WB_selected_reg, o_WB_selected_data, o_WB_valid,
               o_WB_halt, o_retired_count
    );
endinterface
`default_nettype wire

// File: rtl/wb_stage_ext.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage_ext
// Brief    : MIPS MEM/WB register, load extension, WB source select, retire/halt.
// Revision : 1.0
// ============================================================================
module wb_stage_ext #(
    parameter int NB_DATA     = 32,
    parameter int NB_REG      = 5,
    parameter int NB_PC       = 32,
    parameter int LINK_REG    = 31,
    parameter int LINK_OFFSET = 8,
    parameter int NB_CNT      = 32
) (
    input  wire logic      i_clock,
    input  wire logic      i_reset,
    wb_stage_ext_if.slave  bus
);
    localparam logic [NB_PC-1:0]  c_link_offset = NB_PC'(LINK_OFFSET);
    localparam logic [NB_REG-1:0] c_link_reg    = NB_REG'(LINK_REG);

    logic               r_valid;
    logic               r_reg_write;
    logic [NB_REG-1:0]  r_reg;
    logic [NB_DATA-1:0] r_data;
    logic               r_halt;
    logic [NB_CNT-1:0]  r_count;

    logic               w_capture;
    logic [7:0]         w_lane_byte;
    logic [15:0]        w_lane_half;
    logic [NB_DATA-1:0] w_load_data;
    logic [NB_PC-1:0]   w_link_pc;
    logic [NB_DATA-1:0] w_wb_data;
    logic [NB_REG-1:0]  w_wb_reg;

    assign w_capture = !bus.i_flush && bus.i_enable && !r_halt;
    assign w_link_pc = bus.i_MEM_pc + c_link_offset;

    // Little-endian lane pick; half-word ignores byte_offset[0].
    always_comb begin
        w_lane_byte = 8'h00;
        w_lane_half = 16'h0000;
        case (bus.i_MEM_byte_offset)
            2'd0:    w_lane_byte = bus.i_MEM_mem_data[7:0];
            2'd1:    w_lane_byte = bus.i_MEM_mem_data[15:8];
            2'd2:    w_lane_byte = bus.i_MEM_mem_data[23:16];
            default: w_lane_byte = bus.i_MEM_mem_data[31:24];
        endcase
        if (bus.i_MEM_byte_offset[1]) w_lane_half = bus.i_MEM_mem_data[31:16];
        else                          w_lane_half = bus.i_MEM_mem_data[15:0];
    end

    always_comb begin
        w_load_data = bus.i_MEM_mem_data;
        case (bus.i_MEM_load_size)
            2'b00: begin
                w_load_data = {{(NB_DATA-8){w_lane_byte[7] & !bus.i_MEM_load_unsigned}},
                               w_lane_byte};
            end
            2'b01: begin
                w_load_data = {{(NB_DATA-16){w_lane_half[15] & !bus.i_MEM_load_unsigned}},
                               w_lane_half};
            end
            default: w_load_data = bus.i_MEM_mem_data;
        endcase
    end

    always_comb begin
        w_wb_data = bus.i_MEM_alu_result;
        w_wb_reg  = bus.i_MEM_selected_reg;
        if (bus.i_MEM_r31_ctrl) begin
            w_wb_data = NB_DATA'(w_link_pc);
            w_wb_reg  = c_link_reg;
        end else if (bus.i_MEM_mem_to_reg) begin
            w_wb_data = w_load_data;
        end
    end

    // Halt is sticky across flushes; only reset clears it.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_reg       <= '0;
            r_data      <= '0;
            r_halt      <= 1'b0;
            r_count     <= '0;
        end else if (bus.i_flush) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_reg       <= '0;
            r_data      <= '0;
        end else if (w_capture) begin
            r_valid     <= bus.i_MEM_valid;
            r_reg_write <= bus.i_MEM_reg_write;
            r_reg       <= w_wb_reg;
            r_data      <= w_wb_data;
            if (bus.i_MEM_valid) begin
                r_count <= r_count + 1'b1;
                if (bus.i_MEM_halt) r_halt <= 1'b1;
            end
        end
    end

    assign bus.o_WB_reg_write     = r_valid && r_reg_write && (r_reg != '0);
    assign bus.o_WB_selected_reg  = r_reg;
    assign bus.o_WB_selected_data = r_data;
    assign bus.o_WB_valid         = r_valid;
    assign bus.o_WB_halt          = r_halt;
    assign bus.o_retired_count    = r_count;
endmodule
`default_nettype wire

// File: tb/tb_wb_stage_ext.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_stage_ext
// Brief    : Directed-vector bench for wb_stage_ext (4-bit retire counter).
// Revision : 1.0
// ============================================================================
module tb_wb_stage_ext;
    logic       clk;
    logic       rst_n;
    int         n_vec;
    int         n_err;
    logic [3:0] exp_cnt;

    wb_stage_ext_if #(.NB_DATA(32), .NB_REG(5), .NB_PC(32), .NB_CNT(4)) bus ();

    wb_stage_ext #(
        .NB_DATA(32), .NB_REG(5), .NB_PC(32),
        .LINK_REG(31), .LINK_OFFSET(8), .NB_CNT(4)
    ) dut (
        .i_clock (clk),
        .i_reset (rst_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.i_enable            = 1'b0;
        bus.i_flush             = 1'b0;
        bus.i_MEM_valid         = 1'b0;
        bus.i_MEM_reg_write     = 1'b0;
        bus.i_MEM_mem_to_reg    = 1'b0;
        bus.i_MEM_r31_ctrl      = 1'b0;
        bus.i_MEM_load_size     = 2'b10;
        bus.i_MEM_load_unsigned = 1'b0;
        bus.i_MEM_byte_offset   = 2'b00;
        bus.i_MEM_mem_data      = 32'h0;
        bus.i_MEM_alu_result    = 32'h0;
        bus.i_MEM_selected_reg  = 5'd0;
        bus.i_MEM_pc            = 32'h0;
        bus.i_MEM_halt          = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        n_vec++;
        if (bus.o_WB_valid !== 1'b0 || bus.o_WB_reg_write !== 1'b0 || bus.o_WB_halt !== 1'b0) begin
            n_err++;
            $display("FAIL reset_flags: valid=%b rw=%b halt=%b, required 0 0 0",
                     bus.o_WB_valid, bus.o_WB_reg_write, bus.o_WB_halt);
        end
        n_vec++;
        if (bus.o_WB_selected_data !== 32'h0 || bus.o_WB_selected_reg !== 5'd0 ||
            bus.o_retired_count !== 4'd0) begin
            n_err++;
            $display("FAIL reset_values: data=%h reg=%0d cnt=%0d, required 0 0 0",
                     bus.o_WB_selected_data, bus.o_WB_selected_reg, bus.o_retired_count);
        end
        rst_n = 1'b1;
        exp_cnt = 4'd0;
    endtask

    task automatic test_alu();
        idle_inputs();
        bus.i_enable         = 1'b1;
        bus.i_MEM_valid      = 1'b1;
        bus.i_MEM_reg_write  = 1'b1;
        bus.i_MEM_alu_result = 32'hBB;
        bus.i_MEM_mem_data   = 32'hAA;
        bus.i_MEM_selected_reg = 5'd5;
        tick();
        exp_cnt = exp_cnt + 4'd1;
        n_vec++;
        if (bus.o_WB_selected_data !== 32'hBB || bus.o_WB_selected_reg !== 5'd5) begin
            n_err++;
            $display("FAIL alu_data: data=%h reg=%0d, required 000000bb 5",
                     bus.o_WB_selected_data, bus.o_WB_selected_reg);
        end
        n_vec++;
        if (bus.o_WB_reg_write !== 1'b1 || bus.o_WB_valid !== 1'b1 || bus.o_retired_count !== exp_cnt) begin
            n_err++;
            $display("FAIL alu_ctrl: rw=%b valid=%b cnt=%0d, required 1 1 %0d",
                     bus.o_WB_reg_write, bus.o_WB_valid, bus.o_retired_count, exp_cnt);
        end
    endtask

    task automatic test_loads();
        logic [1:0]  sz  [9];
        logic        uns [9];
        logic [1:0]  off [9];
        logic [31:0] exp [9];
        sz[0]=2'b00; uns[0]=0; off[0]=2'd0; exp[0]=32'h00000022;
        sz[1]=2'b00; uns[1]=0; off[1]=2'd1; exp[1]=32'h0000007F;
        sz[2]=2'b00; uns[2]=0; off[2]=2'd2; exp[2]=32'hFFFFFFF1;
        sz[3]=2'b00; uns[3]=0; off[3]=2'd3; exp[3]=32'hFFFFFF80;
        sz[4]=2'b01; uns[4]=0; off[4]=2'd2; exp[4]=32'hFFFF80F1;
        sz[5]=2'b01; uns[5]=1; off[5]=2'd2; exp[5]=32'h000080F1;
        sz[6]=2'b10; uns[6]=0; off[6]=2'd0; exp[6]=32'h80F17F22;
        sz[7]=2'b00; uns[7]=1; off[7]=2'd3; exp[7]=32'h00000080;
        sz[8]=2'b01; uns[8]=0; off[8]=2'd1; exp[8]=32'h00007F22;
        idle_inputs();
        bus.i_enable         = 1'b1;
        bus.i_MEM_valid      = 1'b1;
        bus.i_MEM_reg_write  = 1'b1;
        bus.i_MEM_mem_to_reg = 1'b1;
        bus.i_MEM_mem_data   = 32'h80F17F22;
        bus.i_MEM_alu_result = 32'h12345678;
        bus.i_MEM_selected_reg = 5'd9;
        for (int i = 0; i < 9; i++) begin
            bus.i_MEM_load_size     = sz[i];
            bus.i_MEM_load_unsigned = uns[i];
            bus.i_MEM_byte_offset   = off[i];
            tick();
            exp_cnt = exp_cnt + 4'd1;
            n_vec++;
            if (bus.o_WB_selected_data !== exp[i]) begin
                n_err++;
                $display("FAIL load_%0d: data=%h, required %h", i, bus.o_WB_selected_data, exp[i]);
            end
        end
        n_vec++;
        if (bus.o_retired_count !== exp_cnt) begin
            n_err++;
            $display("FAIL load_count: cnt=%0d, required %0d", bus.o_retired_count, exp_cnt);
        end
    endtask

    task automatic test_link();
        idle_inputs();
        bus.i_enable         = 1'b1;
        bus.i_MEM_valid      = 1'b1;
        bus.i_MEM_reg_write  = 1'b1;
        bus.i_MEM_mem_to_reg = 1'b1;
        bus.i_MEM_r31_ctrl   = 1'b1;
        bus.i_MEM_pc         = 32'h100;
        bus.i_MEM_mem_data   = 32'hDEADBEEF;
        bus.i_MEM_alu_result = 32'h55;
        bus.i_MEM_selected_reg = 5'd7;
        tick();
        exp_cnt = exp_cnt + 4'd1;
        n_vec++;
        if (bus.o_WB_selected_reg !== 5'd31 || bus.o_WB_selected_data !== 32'h108 ||
            bus.o_WB_reg_write !== 1'b1) begin
            n_err++;
            $display("FAIL link: reg=%0d data=%h rw=%b, required 31 00000108 1",
                     bus.o_WB_selected_reg, bus.o_WB_selected_data, bus.o_WB_reg_write);
        end
        bus.i_MEM_pc = 32'hFFFFFFFC;
        tick();
        exp_cnt = exp_cnt + 4'd1;
        n_vec++;
        if (bus.o_WB_selected_data !== 32'h00000004) begin
            n_err++;
            $display("FAIL link_wrap: data=%h, required 00000004", bus.o_WB_selected_data);
        end
    endtask

    task automatic test_zero_bubble_hold();
        idle_inputs();
        bus.i_enable         = 1'b1;
        bus.i_MEM_valid      = 1'b1;
        bus.i_MEM_reg_write  = 1'b1;
        bus.i_MEM_alu_result = 32'hCAFE;
        bus.i_MEM_selected_reg = 5'd0;
        tick();
        exp_cnt = exp_cnt + 4'd1;
        n_vec++;
        if (bus.o_WB_reg_write !== 1'b0 || bus.o_WB_valid !== 1'b1 ||
            bus.o_WB_selected_data !== 32'hCAFE) begin
            n_err++;
            $display("FAIL zero_reg: rw=%b valid=%b data=%h, required 0 1 0000cafe",
                     bus.o_WB_reg_write, bus.o_WB_valid, bus.o_WB_selected_data);
        end
        bus.i_flush = 1'b1;
        bus.i_MEM_selected_reg = 5'd4;
        tick();
        n_vec++;
        if (bus.o_WB_valid !== 1'b0 || bus.o_WB_reg_write !== 1'b0 || bus.o_WB_selected_data !== 32'h0 ||
            bus.o_WB_selected_reg !== 5'd0 || bus.o_retired_count !== exp_cnt) begin
            n_err++;
            $display("FAIL flush: valid=%b rw=%b data=%h reg=%0d cnt=%0d, required 0 0 0 0 %0d",
                     bus.o_WB_valid, bus.o_WB_reg_write, bus.o_WB_selected_data,
                     bus.o_WB_selected_reg, bus.o_retired_count, exp_cnt);
        end
        bus.i_flush = 1'b0;
        bus.i_MEM_alu_result = 32'h1234;
        bus.i_MEM_selected_reg = 5'd3;
        tick();
        exp_cnt = exp_cnt + 4'd1;
        bus.i_enable = 1'b0;
        bus.i_MEM_alu_result = 32'h9999;
        bus.i_MEM_selected_reg = 5'd12;
        tick();
        tick();
        n_vec++;
        if (bus.o_WB_selected_data !== 32'h1234 || bus.o_WB_selected_reg !== 5'd3 ||
            bus.o_WB_reg_write !== 1'b1 || bus.o_retired_count !== exp_cnt) begin
            n_err++;
            $display("FAIL hold: data=%h reg=%0d rw=%b cnt=%0d, required 00001234 3 1 %0d",
                     bus.o_WB_selected_data, bus.o_WB_selected_reg, bus.o_WB_reg_write,
                     bus.o_retired_count, exp_cnt);
        end
    endtask

    task automatic test_wrap();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_cnt = 4'd0;
        bus.i_enable    = 1'b1;
        bus.i_MEM_valid = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            tick();
            if (i == 16) begin
                n_vec++;
                if (bus.o_retired_count !== 4'd0) begin
                    n_err++;
                    $display("FAIL wrap_16: cnt=%0d, required 0", bus.o_retired_count);
                end
            end
        end
        exp_cnt = 4'd1;
        n_vec++;
        if (bus.o_retired_count !== 4'd1) begin
            n_err++;
            $display("FAIL wrap_17: cnt=%0d, required 1", bus.o_retired_count);
        end
    endtask

    task automatic test_halt();
        idle_inputs();
        bus.i_enable         = 1'b1;
        bus.i_MEM_valid      = 1'b1;
        bus.i_MEM_reg_write  = 1'b1;
        bus.i_MEM_halt       = 1'b1;
        bus.i_MEM_alu_result = 32'hA5;
        bus.i_MEM_selected_reg = 5'd2;
        tick();
        exp_cnt = exp_cnt + 4'd1;
        n_vec++;
        if (bus.o_WB_halt !== 1'b1 || bus.o_retired_count !== exp_cnt) begin
            n_err++;
            $display("FAIL halt_set: halt=%b cnt=%0d, required 1 %0d",
                     bus.o_WB_halt, bus.o_retired_count, exp_cnt);
        end
        bus.i_MEM_halt       = 1'b0;
        bus.i_MEM_alu_result = 32'h77;
        bus.i_MEM_selected_reg = 5'd6;
        tick();
        tick();
        n_vec++;
        if (bus.o_WB_selected_data !== 32'hA5 || bus.o_WB_selected_reg !== 5'd2 ||
            bus.o_retired_count !== exp_cnt) begin
            n_err++;
            $display("FAIL halt_block: data=%h reg=%0d cnt=%0d, required 000000a5 2 %0d",
                     bus.o_WB_selected_data, bus.o_WB_selected_reg, bus.o_retired_count, exp_cnt);
        end
        bus.i_flush = 1'b1;
        tick();
        bus.i_flush = 1'b0;
        n_vec++;
        if (bus.o_WB_valid !== 1'b0 || bus.o_WB_halt !== 1'b1 || bus.o_WB_selected_data !== 32'h0) begin
            n_err++;
            $display("FAIL halt_flush: valid=%b halt=%b data=%h, required 0 1 0",
                     bus.o_WB_valid, bus.o_WB_halt, bus.o_WB_selected_data);
        end
    endtask

    task automatic test_async_reset();
        // Load non-zero state around a halted pipe, then drop reset between edges.
        bus.i_enable = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (bus.o_WB_halt !== 1'b0 || bus.o_retired_count !== 4'd0 || bus.o_WB_valid !== 1'b0 ||
            bus.o_WB_reg_write !== 1'b0 || bus.o_WB_selected_data !== 32'h0 ||
            bus.o_WB_selected_reg !== 5'd0) begin
            n_err++;
            $display("FAIL async_reset: halt=%b cnt=%0d valid=%b rw=%b data=%h reg=%0d, required all 0",
                     bus.o_WB_halt, bus.o_retired_count, bus.o_WB_valid, bus.o_WB_reg_write,
                     bus.o_WB_selected_data, bus.o_WB_selected_reg);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 4'd0;
        tick();
        exp_cnt = exp_cnt + 4'd1;
        n_vec++;
        if (bus.o_retired_count !== exp_cnt || bus.o_WB_valid !== 1'b1) begin
            n_err++;
            $display("FAIL post_reset_capture: cnt=%0d valid=%b, required %0d 1",
                     bus.o_retired_count, bus.o_WB_valid, exp_cnt);
        end
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        exp_cnt = 4'd0;
        rst_n   = 1'b0;
        idle_inputs();
        test_reset();
        test_alu();
        test_loads();
        test_link();
        test_zero_bubble_hold();
        test_wrap();
        test_halt();
        bus.i_MEM_valid = 1'b1;
        bus.i_MEM_reg_write = 1'b1;
        bus.i_MEM_alu_result = 32'h3C;
        bus.i_MEM_selected_reg = 5'd8;
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
